// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time to the
// instruction memory, captures the returned word into the IF/ID register, and
// uses a single-entry skid buffer so a response arriving while decode is
// stalled is never lost. Redirects from jump_decision flush everything held.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        accept;
    logic        resp;
    logic        if_free;
    logic        skid_load;

    // A request is only offered while enabled, out of reset, and with room
    // downstream: a full skid buffer means the response would have nowhere to go.
    assign imem_req  = clk_en && !rst && (state == REQ) && !skid_valid;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    // rvalid outside WAIT is either a protocol violation or a dropped response.
    assign resp      = imem_rvalid && (state == WAIT);
    assign if_free   = !if_valid || !stall;
    // Response goes to the skid buffer when IF/ID cannot take it this cycle
    // (held by stall, or the skid contents move into IF/ID first).
    assign skid_load = resp && !(if_free && !skid_valid);

    // Next-state logic; a jump only changes the path when a request is in flight.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (accept) begin
                    state_next = jump_en ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end else if (jump_en) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; clk_en freezes the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    // Program counter: redirect wins over sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (clk_en) begin
            if (jump_en) begin
                pc <= jump_addr & ALIGN_MASK;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Remember which PC the outstanding request belongs to.
    always_ff @(posedge clk) begin
        if (clk_en && accept) begin
            req_pc <= pc;
        end
    end

    // IF/ID register and skid valid: skid drains first, then fresh memory data.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid   <= 1'b0;
            if_pc      <= 32'h0000_0000;
            if_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (clk_en) begin
            if (jump_en) begin
                if_valid   <= 1'b0;
                if_instr   <= NOP_INSTR;
                skid_valid <= 1'b0;
            end else begin
                if (if_free) begin
                    if (skid_valid) begin
                        if_valid <= 1'b1;
                        if_pc    <= skid_pc;
                        if_instr <= skid_instr;
                    end else if (resp) begin
                        if_valid <= 1'b1;
                        if_pc    <= req_pc;
                        if_instr <= imem_rdata;
                    end else if (if_valid) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                end
                if (skid_load) begin
                    skid_valid <= 1'b1;
                end else if (if_free) begin
                    skid_valid <= 1'b0;
                end
            end
        end
    end

    // Skid payload; its valid bit alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (clk_en && !jump_en && skid_load) begin
            skid_pc    <= req_pc;
            skid_instr <= imem_rdata;
        end
    end

endmodule
